// File: rtl/signed_divider_if.sv
// Handshake and data bundle for signed_divider.
// The master side (testbench or upstream logic) drives start/din/W and
// observes busy/done/dout/ovf/dz; the slave side is the divider itself.
interface signed_divider_if;
    logic        start;
    logic [15:0] din;
    logic [7:0]  W;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic        ovf;
    logic        dz;

    modport master (
        output start, din, W,
        input  busy, done, dout, ovf, dz
    );

    modport slave (
        input  start, din, W,
        output busy, done, dout, ovf, dz
    );
endinterface

// File: rtl/signed_divider.sv
// Sequential signed divider: Q8.8 dividend divided by a Q2.6 divisor,
// producing a saturated Q8.8 quotient after a fixed 23-cycle latency.
// The magnitude quotient is built by 22 restoring shift-subtract steps,
// then FINISH applies the sign, saturates and registers the outputs.
// Optional build macro: SIGNED_DIVIDER_ROUND_EN selects round-to-nearest
// (ties away from zero) instead of the default truncation toward zero.
module signed_divider (
    input  logic            clk,
    input  logic            rst,
    signed_divider_if.slave io_div
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [21:0] r_quo;
    logic [7:0]  r_rem;
    logic [7:0]  r_divMag;
    logic        r_neg;
    logic        r_dinNeg;

    logic [15:0] w_dinMag;
    logic [7:0]  w_wMag;
    logic [8:0]  w_trial;
    logic        w_fits;
    logic [7:0]  w_nextRem;
    logic        w_roundUp;
    logic [22:0] w_mag;
    logic [15:0] w_result;
    logic        w_ovf;

    // Two's-complement magnitudes; -32768 and -128 map onto 32768 and 128 unsigned.
    assign w_dinMag = io_div.din[15] ? (~io_div.din + 16'd1) : io_div.din;
    assign w_wMag   = io_div.W[7]    ? (~io_div.W + 8'd1)    : io_div.W;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    assign w_trial   = {r_rem, r_quo[21]};
    assign w_fits    = (w_trial >= {1'b0, r_divMag});
    assign w_nextRem = w_fits ? 8'(w_trial - {1'b0, r_divMag}) : w_trial[7:0];

`ifdef SIGNED_DIVIDER_ROUND_EN
    // Round half away from zero on the magnitude: bump when 2*remainder >= |W|.
    assign w_roundUp = ({r_rem, 1'b0} >= {1'b0, r_divMag});
`else
    assign w_roundUp = 1'b0;
`endif

    assign w_mag = {1'b0, r_quo} + {22'd0, w_roundUp};

    // Apply sign and saturate the magnitude; a zero divisor overrides everything.
    always_comb begin
        w_result = 16'h0000;
        w_ovf    = 1'b0;
        if (r_divMag == 8'd0) begin
            w_result = r_dinNeg ? 16'h8000 : 16'h7FFF;
        end else if (r_neg) begin
            if (w_mag > 23'd32768) begin
                w_result = 16'h8000;
                w_ovf    = 1'b1;
            end else begin
                w_result = ~w_mag[15:0] + 16'd1;
            end
        end else begin
            if (w_mag > 23'd32767) begin
                w_result = 16'h7FFF;
                w_ovf    = 1'b1;
            end else begin
                w_result = w_mag[15:0];
            end
        end
    end

    // Control FSM, iteration datapath and registered outputs in one process.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 5'd0;
            r_quo       <= 22'd0;
            r_rem       <= 8'd0;
            r_divMag    <= 8'd0;
            r_neg       <= 1'b0;
            r_dinNeg    <= 1'b0;
            io_div.busy <= 1'b0;
            io_div.done <= 1'b0;
            io_div.dout <= 16'h0000;
            io_div.ovf  <= 1'b0;
            io_div.dz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    io_div.done <= 1'b0;
                    if (io_div.start) begin
                        r_quo       <= {w_dinMag, 6'b000000};
                        r_rem       <= 8'd0;
                        r_divMag    <= w_wMag;
                        r_neg       <= io_div.din[15] ^ io_div.W[7];
                        r_dinNeg    <= io_div.din[15];
                        r_cnt       <= 5'd0;
                        io_div.busy <= 1'b1;
                        r_state     <= CALC;
                    end else begin
                        io_div.busy <= 1'b0;
                    end
                end
                CALC: begin
                    r_quo <= {r_quo[20:0], w_fits};
                    r_rem <= w_nextRem;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd21) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    io_div.dout <= w_result;
                    io_div.ovf  <= w_ovf;
                    io_div.dz   <= (r_divMag == 8'd0);
                    io_div.done <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: directed corner cases, control
// scenarios (held start, reset abort) and randomized operands compared
// against an integer-arithmetic reference model.
// Honours SIGNED_DIVIDER_ROUND_EN so it can check either build.
module tb_signed_divider;

    logic clk;
    logic rst;
    int   testsRun;
    int   failCount;

    signed_divider_if busIf ();

    signed_divider dut (
        .clk    (clk),
        .rst    (rst),
        .io_div (busIf.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count a comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: R = (din*64)/W on plain integers, then sign and saturation.
    function automatic void modelDivide(input logic [15:0] a, input logic [7:0] b,
                                        output logic [15:0] q, output logic ovf,
                                        output logic dz);
        longint num;
        longint den;
        longint mag;
        longint rem;
        longint res;
        bit     neg;
        num = longint'($signed(a)) * 64;
        den = longint'($signed(b));
        if (den == 0) begin
            dz  = 1'b1;
            ovf = 1'b0;
            q   = ($signed(a) >= 0) ? 16'h7FFF : 16'h8000;
            return;
        end
        dz  = 1'b0;
        neg = (num < 0) != (den < 0);
        if (num < 0) num = -num;
        if (den < 0) den = -den;
        mag = num / den;
        rem = num % den;
`ifdef SIGNED_DIVIDER_ROUND_EN
        if (2 * rem >= den) mag = mag + 1;
`else
        if (rem < 0) mag = mag;
`endif
        res = neg ? -mag : mag;
        if (res > 32767) begin
            q   = 16'h7FFF;
            ovf = 1'b1;
        end else if (res < -32768) begin
            q   = 16'h8000;
            ovf = 1'b1;
        end else begin
            q   = res[15:0];
            ovf = 1'b0;
        end
    endfunction

    // Run one division with a start pulse, scramble the inputs afterwards,
    // and check latency, results and that the results are held.
    task automatic applyStimulus(input string tag, input logic [15:0] a,
                                 input logic [7:0] b, input logic [15:0] expDout,
                                 input logic expOvf, input logic expDz);
        int edges;
        @(negedge clk);
        busIf.start = 1'b1;
        busIf.din   = a;
        busIf.W     = b;
        @(posedge clk);
        #1;
        busIf.start = 1'b0;
        busIf.din   = 16'($urandom);
        busIf.W     = 8'($urandom);
        checkOutput({tag, "_busy"}, 32'(busIf.busy), 32'd1);
        edges = 0;
        while (!busIf.done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput({tag, "_latency"}, 32'(edges), 32'd23);
        checkOutput({tag, "_dout"}, 32'(busIf.dout), 32'(expDout));
        checkOutput({tag, "_ovf"}, 32'(busIf.ovf), 32'(expOvf));
        checkOutput({tag, "_dz"}, 32'(busIf.dz), 32'(expDz));
        checkOutput({tag, "_busyDone"}, 32'(busIf.busy), 32'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, "_donePulse"}, 32'(busIf.done), 32'd0);
        checkOutput({tag, "_hold"}, 32'(busIf.dout), 32'(expDout));
    endtask

    initial begin
        logic [15:0] rDin;
        logic [7:0]  rW;
        logic [15:0] mQ;
        logic        mOvf;
        logic        mDz;
        int          doneAt[$];
        int          doneSeen;

        testsRun    = 0;
        failCount   = 0;
        rst         = 1'b1;
        busIf.start = 1'b0;
        busIf.din   = 16'h0000;
        busIf.W     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_dout", 32'(busIf.dout), 32'd0);
        checkOutput("rst_busy", 32'(busIf.busy), 32'd0);
        checkOutput("rst_done", 32'(busIf.done), 32'd0);
        checkOutput("rst_ovf", 32'(busIf.ovf), 32'd0);
        checkOutput("rst_dz", 32'(busIf.dz), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("d4by1", 16'h0400, 8'h40, 16'h0400, 1'b0, 1'b0);
        applyStimulus("d4byHalf", 16'h0400, 8'h20, 16'h0800, 1'b0, 1'b0);
        applyStimulus("dNeg10", 16'hF600, 8'hC0, 16'h0A00, 1'b0, 1'b0);
        applyStimulus("dSatPos", 16'hBC00, 8'hE0, 16'h7FFF, 1'b1, 1'b0);
        applyStimulus("dMinExact", 16'h8000, 8'h40, 16'h8000, 1'b0, 1'b0);
`ifdef SIGNED_DIVIDER_ROUND_EN
        applyStimulus("dRoundTie", 16'h0003, 8'h80, 16'hFFFE, 1'b0, 1'b0);
`else
        applyStimulus("dRoundTie", 16'h0003, 8'h80, 16'hFFFF, 1'b0, 1'b0);
`endif
        applyStimulus("dBy63", 16'h0100, 8'h3F, 16'h0104, 1'b0, 1'b0);
        applyStimulus("dZeroDin", 16'h0000, 8'h25, 16'h0000, 1'b0, 1'b0);
        applyStimulus("dZeroBoth", 16'h0000, 8'h00, 16'h7FFF, 1'b0, 1'b1);
        applyStimulus("dDzPos", 16'h0400, 8'h00, 16'h7FFF, 1'b0, 1'b1);
        applyStimulus("dDzNeg", 16'hFC00, 8'h00, 16'h8000, 1'b0, 1'b1);

        // Reset in the middle of CALC, with a start in the reset cycle.
        @(negedge clk);
        busIf.start = 1'b1;
        busIf.din   = 16'h0400;
        busIf.W     = 8'h40;
        @(posedge clk);
        #1;
        busIf.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst         = 1'b1;
        busIf.start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_dout", 32'(busIf.dout), 32'd0);
        checkOutput("abort_dz", 32'(busIf.dz), 32'd0);
        checkOutput("abort_busy", 32'(busIf.busy), 32'd0);
        checkOutput("abort_done", 32'(busIf.done), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        busIf.start = 1'b0;
        doneSeen    = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (busIf.done) doneSeen++;
        end
        checkOutput("abort_noDone", 32'(doneSeen), 32'd0);
        checkOutput("abort_idleBusy", 32'(busIf.busy), 32'd0);
        applyStimulus("afterAbort", 16'h0400, 8'h40, 16'h0400, 1'b0, 1'b0);

        // Start held high: accepted only in IDLE, one done every 24 cycles.
        @(negedge clk);
        busIf.start = 1'b1;
        busIf.din   = 16'h0400;
        busIf.W     = 8'h20;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (busIf.done) doneAt.push_back(c);
        end
        checkOutput("held_count", 32'(doneAt.size()), 32'd3);
        if (doneAt.size() >= 3) begin
            checkOutput("held_first", 32'(doneAt[0]), 32'd23);
            checkOutput("held_gap1", 32'(doneAt[1] - doneAt[0]), 32'd24);
            checkOutput("held_gap2", 32'(doneAt[2] - doneAt[1]), 32'd24);
        end
        checkOutput("held_dout", 32'(busIf.dout), 32'h0800);
        @(negedge clk);
        busIf.start = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Randomized operands, with zero and tiny divisors mixed in.
        for (int n = 0; n < 40; n++) begin
            rDin = 16'($urandom);
            case (n % 5)
                0:       rW = 8'h00;
                1:       rW = 8'($urandom_range(1, 4));
                2:       rW = 8'($urandom_range(252, 255));
                default: rW = 8'($urandom);
            endcase
            if (n % 7 == 3) rDin = 16'h8000;
            modelDivide(rDin, rW, mQ, mOvf, mDz);
            applyStimulus("rand", rDin, rW, mQ, mOvf, mDz);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 The block SHALL have no parameters; formats are fixed: dividend/result Q8.8 signed 16-bit, divisor Q2.6 signed 8-bit (same formats as signed_multiplier).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a division; sampled only while idle.
REQ-006 din  input  16  signed Q8.8 dividend.
REQ-007 W  input  8  signed Q2.6 divisor.
REQ-008 busy  output  1  high while a division is in progress, including the done cycle.
REQ-009 done  output  1  one-cycle pulse marking dout/ovf/dz valid.
REQ-010 dout  output  16  signed Q8.8 quotient, held until the next done.
REQ-011 ovf  output  1  quotient saturated; valid with done, held with dout.
REQ-012 dz  output  1  divisor was zero; valid with done, held with dout.

Function
REQ-013 The result SHALL be R = (din * 64) / W as integers: din/256 divided by W/64, expressed in Q8.8.
REQ-014 The FSM SHALL have states IDLE, CALC, FINISH; reset state IDLE.
REQ-015 IDLE with start=1 at edge 0: latch din and W, latch the result sign (din[15] XOR W[7]), latch magnitudes (|din| shifted left 6 = 22 bits; |W| = 8 bits, -128 allowed), and go to CALC.
REQ-016 CALC SHALL run exactly 22 restoring shift-subtract iterations, one quotient bit per cycle, counted by a 5-bit counter; after the 22nd iteration it SHALL go to FINISH.
REQ-017 On entry to FINISH the block SHALL apply the sign, then saturate, then register dout, ovf and dz, with done=1 for that single cycle; the next state SHALL be IDLE.
REQ-018 done SHALL rise exactly 23 rising edges after the edge that accepted start; start to done latency is 23 cycles, fixed, including the divide-by-zero case.
REQ-019 busy SHALL be high from edge 1 through the done cycle, and low in IDLE.
REQ-020 start SHALL be ignored while busy=1, including in the done cycle; a new start SHALL be accepted on the first IDLE cycle.
REQ-021 Default rounding SHALL truncate toward zero.
REQ-022 Saturation: a positive result > 32767 SHALL give 0x7FFF; a negative result with magnitude > 32768 SHALL give 0x8000; in both cases ovf=1. Exactly -32768 is representable and SHALL NOT set ovf.
REQ-023 If W == 0, dz=1 and ovf=0; dout = 0x7FFF if din >= 0, else 0x8000.
REQ-024 If din == 0 and W != 0, dout = 0x0000, ovf=0, dz=0.
REQ-025 Input changes on din or W after acceptance SHALL NOT affect the result in progress.

Reset
REQ-026 rst=1 at any edge SHALL force IDLE, clear the iteration counter and the working registers, and set dout=0, busy=0, done=0, ovf=0, dz=0.
REQ-027 A reset during CALC or FINISH SHALL abort the operation with no done pulse; a start sampled in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-028 With macro SIGNED_DIVIDER_ROUND_EN defined, FINISH SHALL round the magnitude to nearest, ties away from zero: increment if 2*remainder >= |W|. The increment is applied before the sign and before saturation, and it may itself cause ovf.
REQ-029 Without SIGNED_DIVIDER_ROUND_EN, truncation per REQ-021 applies; latency is identical in both builds.

Verification
REQ-030 din=0x0400 (4.0), W=0x40 (1.0), start pulse -> 23 cycles later done=1, dout=0x0400, ovf=0, dz=0.
REQ-031 din=0x0400, W=0x20 (0.5) -> dout=0x0800 (8.0); din=0xF600 (-10), W=0xC0 (-1) -> dout=0x0A00 (10).
REQ-032 din=0xBC00 (-68), W=0xE0 (-0.5) -> dout=0x7FFF, ovf=1; din=0x8000, W=0x40 -> dout=0x8000, ovf=0.
REQ-033 din=0x0003, W=0x80 (-2) -> dout=0xFFFF without SIGNED_DIVIDER_ROUND_EN, 0xFFFE with it; din=0x0100, W=0x3F -> dout=0x0104 in both builds.
REQ-034 din=0x0400, W=0x00 -> dout=0x7FFF, dz=1, ovf=0, done still at 23 cycles; din=0xFC00, W=0x00 -> dout=0x8000, dz=1.
REQ-035 Control scenarios:
- start held high continuously -> a new division begins only on IDLE cycles, one done per 24 cycles.
- rst=1 at CALC cycle 10 -> no done pulse, all outputs 0; next start completes normally.
